// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared states, defaults and width helper for the oversampled UART receiver
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_state_t;

    localparam int UART_OVERSAMPLING = 8;
    localparam int UART_DATA_BITS    = 8;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_sync_filter.sv
// rtl/uart_rx_sync_filter.sv - rxd 2-flop synchronizer plus tick-gated 3-sample majority filter
module uart_rx_sync_filter (
    input  logic clk,
    input  logic rst_n,
    input  logic rxd,
    input  logic tick,
    output logic rx_f
);

    logic [1:0] sync;
    logic [2:0] samples;

    // Everything resets to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= 2'b11;
            samples <= 3'b111;
        end else begin
            sync <= {sync[0], rxd};
            if (tick) begin
                samples <= {samples[1:0], sync[1]};
            end
        end
    end

    assign rx_f = (samples[0] & samples[1]) |
                  (samples[0] & samples[2]) |
                  (samples[1] & samples[2]);

endmodule

// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - 8N1 UART receiver driven by an oversampled baud tick
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int OVERSAMPLING = UART_OVERSAMPLING,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    input  logic                 tick,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_data_ready,
    output logic                 rx_frame_err,
    output logic                 rx_idle
);

    localparam int CNT_W = clog2(OVERSAMPLING);
    localparam int IDX_W = clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLING / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLING - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 rx_f;
    uart_state_t          state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [IDX_W-1:0]     bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [DATA_BITS-1:0] data_n;
    logic                 ready_n;
    logic                 err_n;

    uart_rx_sync_filter u_sync_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .rxd   (rxd),
        .tick  (tick),
        .rx_f  (rx_f)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            rx_data       <= '0;
            rx_data_ready <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            bit_idx       <= bit_idx_n;
            shreg         <= shreg_n;
            rx_data       <= data_n;
            rx_data_ready <= ready_n;
            rx_frame_err  <= err_n;
        end
    end

    // The start bit is checked half a bit in; from there every full bit period lands mid-bit.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        data_n    = rx_data;
        ready_n   = 1'b0;
        err_n     = 1'b0;
        if (tick) begin
            case (state)
                IDLE: begin
                    cnt_n = '0;
                    if (!rx_f) begin
                        state_n = START;
                    end
                end
                START: begin
                    if (cnt == CNT_MID) begin
                        cnt_n = '0;
                        if (!rx_f) begin
                            state_n   = DATA;
                            bit_idx_n = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt_n   = '0;
                        shreg_n = {rx_f, shreg[DATA_BITS-1:1]};
                        if (bit_idx == IDX_LAST) begin
                            state_n = STOP;
                        end else begin
                            bit_idx_n = bit_idx + 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt_n = '0;
                        if (rx_f) begin
                            data_n  = shreg;
                            ready_n = 1'b1;
                            state_n = IDLE;
                        end else begin
                            err_n   = 1'b1;
                            state_n = WAIT_HIGH;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    cnt_n = '0;
                    if (rx_f) begin
                        state_n = IDLE;
                    end
                end
                default: begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign rx_idle = (state == IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb/tb_uart_rx_oversampled.sv - directed self-checking bench for uart_rx_oversampled
module tb_uart_rx_oversampled;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd;
    logic       tick;
    logic [7:0] rx_data;
    logic       rx_data_ready;
    logic       rx_frame_err;
    logic       rx_idle;

    int tests = 0;
    int fails = 0;

    logic       tick_en;
    logic [1:0] tdiv;

    int         cyc = 0;
    int         ready_cnt = 0;
    int         err_cnt = 0;
    int         last_ready_cyc = 0;
    int         prev_ready_cyc = 0;
    int         idle_drops = 0;
    int         zero_cycles = 0;
    int         both_high = 0;
    logic       prev_idle = 1'b1;
    logic [7:0] last_ready_data = 8'h00;

    int         d0;
    int         z0;
    logic [9:0] f;

    uart_rx_oversampled #(
        .OVERSAMPLING (8),
        .DATA_BITS    (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rxd           (rxd),
        .tick          (tick),
        .rx_data       (rx_data),
        .rx_data_ready (rx_data_ready),
        .rx_frame_err  (rx_frame_err),
        .rx_idle       (rx_idle)
    );

    always #5 clk = ~clk;

    // One-clock tick every 4 clocks, changed on the falling edge.
    initial begin
        tick = 1'b0;
        tdiv = 2'd0;
        forever begin
            @(negedge clk);
            if (tick_en) begin
                tdiv = tdiv + 2'd1;
                tick = (tdiv == 2'd0);
            end else begin
                tick = 1'b0;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_data_ready) begin
            ready_cnt       = ready_cnt + 1;
            prev_ready_cyc  = last_ready_cyc;
            last_ready_cyc  = cyc;
            last_ready_data = rx_data;
        end
        if (rx_frame_err) err_cnt = err_cnt + 1;
        if (rx_data_ready && rx_frame_err) both_high = both_high + 1;
        if (prev_idle && !rx_idle) idle_drops = idle_drops + 1;
        if (rx_data == 8'h00) zero_cycles = zero_cycles + 1;
        prev_idle = rx_idle;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests = tests + 1;
        assert (got === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_tick();
        @(posedge clk);
        while (!tick) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [9:0] fr, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            rxd = fr[i];
            repeat (8) wait_tick();
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits({1'b1, b, 1'b0}, 0, 9);
    endtask

    initial begin
        rst_n   = 1'b0;
        rxd     = 1'b1;
        tick_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset_rx_data", 32'(rx_data), 32'h00);
        check("reset_ready", 32'(rx_data_ready), 32'h0);
        check("reset_err", 32'(rx_frame_err), 32'h0);
        check("reset_idle", 32'(rx_idle), 32'h1);
        rst_n = 1'b1;
        repeat (16) wait_tick();

        send_byte(8'h55);
        check("f55_ready_cnt", 32'(ready_cnt), 32'd1);
        check("f55_strobe_data", 32'(last_ready_data), 32'h55);
        check("f55_rx_data", 32'(rx_data), 32'h55);
        repeat (8) wait_tick();
        send_byte(8'hA3);
        check("fa3_ready_cnt", 32'(ready_cnt), 32'd2);
        check("fa3_rx_data", 32'(rx_data), 32'hA3);
        check("clean_err_cnt", 32'(err_cnt), 32'd0);

        d0  = idle_drops;
        rxd = 1'b0;
        repeat (2) wait_tick();
        rxd = 1'b1;
        repeat (16) wait_tick();
        check("glitch_left_idle", 32'(idle_drops), 32'(d0 + 1));
        check("glitch_idle", 32'(rx_idle), 32'h1);
        check("glitch_ready_cnt", 32'(ready_cnt), 32'd2);
        check("glitch_err_cnt", 32'(err_cnt), 32'd0);
        check("glitch_rx_data", 32'(rx_data), 32'hA3);

        z0 = zero_cycles;
        send_bits({1'b0, 8'h00, 1'b0}, 0, 9);
        repeat (160) wait_tick();
        check("brk_err_cnt", 32'(err_cnt), 32'd1);
        check("brk_state", 32'(dut.state), 32'(WAIT_HIGH));
        check("brk_idle", 32'(rx_idle), 32'h0);
        check("brk_ready_cnt", 32'(ready_cnt), 32'd2);
        check("brk_rx_data", 32'(rx_data), 32'hA3);
        rxd = 1'b1;
        repeat (16) wait_tick();
        check("brk_release_idle", 32'(rx_idle), 32'h1);
        send_byte(8'h3C);
        check("f3c_ready_cnt", 32'(ready_cnt), 32'd3);
        check("f3c_rx_data", 32'(rx_data), 32'h3C);
        check("f3c_err_cnt", 32'(err_cnt), 32'd1);
        check("brk_never_zero", 32'(zero_cycles), 32'(z0));

        repeat (8) wait_tick();
        send_byte(8'h01);
        check("b2b_first_data", 32'(rx_data), 32'h01);
        send_byte(8'hFF);
        check("b2b_ready_cnt", 32'(ready_cnt), 32'd5);
        check("b2b_second_data", 32'(rx_data), 32'hFF);
        check("b2b_interval", 32'(last_ready_cyc - prev_ready_cyc), 32'd320);

        repeat (8) wait_tick();
        f = {1'b1, 8'h81, 1'b0};
        send_bits(f, 0, 4);
        rxd = f[5];
        repeat (3) wait_tick();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_idle", 32'(rx_idle), 32'h1);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        check("rst_cnt", 32'(dut.cnt), 32'd0);
        rxd   = 1'b1;
        rst_n = 1'b1;
        repeat (16) wait_tick();
        check("rst_no_ready", 32'(ready_cnt), 32'd5);
        check("rst_no_err", 32'(err_cnt), 32'd1);
        send_byte(8'h7E);
        check("f7e_ready_cnt", 32'(ready_cnt), 32'd6);
        check("f7e_rx_data", 32'(rx_data), 32'h7E);

        repeat (8) wait_tick();
        f = {1'b1, 8'h96, 1'b0};
        send_bits(f, 0, 4);
        tick_en = 1'b0;
        rxd     = f[5];
        repeat (1000) @(posedge clk);
        #1;
        check("hold_state", 32'(dut.state), 32'(DATA));
        check("hold_cnt", 32'(dut.cnt), 32'd1);
        check("hold_bit_idx", 32'(dut.bit_idx), 32'd4);
        check("hold_idle", 32'(rx_idle), 32'h0);
        check("hold_ready_cnt", 32'(ready_cnt), 32'd6);
        tick_en = 1'b1;
        repeat (8) wait_tick();
        send_bits(f, 6, 9);
        check("f96_ready_cnt", 32'(ready_cnt), 32'd7);
        check("f96_rx_data", 32'(rx_data), 32'h96);
        check("final_err_cnt", 32'(err_cnt), 32'd1);
        check("never_both_high", 32'(both_high), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
